// File: rtl/stage3_fixed_residual.sv
// Fixed-polynomial (orders 0..4) residual stage with warm-up sample routing.
// Optional clamp of the residual to 16 bits is enabled by defining STAGE3_SATURATE_EN.
module stage3_fixed_residual #(
  parameter int unsigned FRAME_SIZE = 4096
) (
  input  logic        iClock,
  input  logic        iReset_n,
  input  logic        iEnable,
  input  logic        iValid,
  input  logic [15:0] iSample,
  input  logic [2:0]  iOrder,
  output logic        oValid,
  output logic [15:0] oResidual,
  output logic        oWarmValid,
  output logic [15:0] oWarmSample,
  output logic [3:0]  oM,
  output logic        oFrameDone,
  output logic        oOverflow
);

  localparam logic [11:0] LastIdx = 12'(FRAME_SIZE - 1);

  // Frame index and latched order
  logic [11:0] idx_q, idx_d;
  logic [2:0]  order_q, order_d;
  logic [2:0]  order_in;
  logic [2:0]  cur_order;

  // Sample history, x1 is the most recent accepted sample
  logic [15:0] hist1_q, hist2_q, hist3_q, hist4_q;

  // Stage 1: captured sample, history snapshot and per-sample flags
  logic        p1_valid_q;
  logic [15:0] p1_x_q, p1_h1_q, p1_h2_q, p1_h3_q, p1_h4_q;
  logic [2:0]  p1_order_q;
  logic        p1_warm_q, p1_first_q, p1_last_q;
  logic        warm_d;

  // Stage 2: registered outputs
  logic        valid_q, warm_valid_q, frame_done_q, overflow_q, overflow_d;
  logic [15:0] residual_q, warm_sample_q;
  logic [3:0]  m_q;

  logic               accept;
  logic signed [19:0] x0, x1, x2, x3, x4;
  logic signed [19:0] e;
  logic [15:0]        res;
  logic               sat;

  assign accept = iEnable & iValid;

  always_comb begin
    order_in  = (iOrder > 3'd4) ? 3'd4 : iOrder;
    cur_order = (idx_q == 12'd0) ? order_in : order_q;
    order_d   = cur_order;
    idx_d     = (idx_q == LastIdx) ? 12'd0 : idx_q + 12'd1;
    // Samples with index < order have no complete history and go out verbatim.
    warm_d    = idx_q < {9'd0, cur_order};
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      idx_q   <= '0;
      order_q <= '0;
      hist1_q <= '0;
      hist2_q <= '0;
      hist3_q <= '0;
      hist4_q <= '0;
    end else if (accept) begin
      idx_q   <= idx_d;
      order_q <= order_d;
      hist1_q <= iSample;
      hist2_q <= hist1_q;
      hist3_q <= hist2_q;
      hist4_q <= hist3_q;
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      p1_valid_q <= 1'b0;
      p1_x_q     <= '0;
      p1_h1_q    <= '0;
      p1_h2_q    <= '0;
      p1_h3_q    <= '0;
      p1_h4_q    <= '0;
      p1_order_q <= '0;
      p1_warm_q  <= 1'b0;
      p1_first_q <= 1'b0;
      p1_last_q  <= 1'b0;
    end else if (iEnable) begin
      p1_valid_q <= iValid;
      if (iValid) begin
        p1_x_q     <= iSample;
        p1_h1_q    <= hist1_q;
        p1_h2_q    <= hist2_q;
        p1_h3_q    <= hist3_q;
        p1_h4_q    <= hist4_q;
        p1_order_q <= cur_order;
        p1_warm_q  <= warm_d;
        p1_first_q <= (idx_q == 12'd0);
        p1_last_q  <= (idx_q == LastIdx);
      end
    end
  end

  always_comb begin
    x0 = {{4{p1_x_q[15]}},  p1_x_q};
    x1 = {{4{p1_h1_q[15]}}, p1_h1_q};
    x2 = {{4{p1_h2_q[15]}}, p1_h2_q};
    x3 = {{4{p1_h3_q[15]}}, p1_h3_q};
    x4 = {{4{p1_h4_q[15]}}, p1_h4_q};
    case (p1_order_q)
      3'd0:    e = x0;
      3'd1:    e = x0 - x1;
      3'd2:    e = x0 - (x1 <<< 1) + x2;
      3'd3:    e = x0 - 20'sd3 * x1 + 20'sd3 * x2 - x3;
      3'd4:    e = x0 - (x1 <<< 2) + 20'sd6 * x2 - (x3 <<< 2) + x4;
      default: e = x0;
    endcase
  end

`ifdef STAGE3_SATURATE_EN
  always_comb begin
    res = e[15:0];
    sat = 1'b0;
    if (e > 20'sd32767) begin
      res = 16'h7FFF;
      sat = 1'b1;
    end else if (e < -20'sd32768) begin
      res = 16'h8000;
      sat = 1'b1;
    end
  end
`else
  always_comb begin
    res = e[15:0];
    sat = 1'b0;
  end
`endif

  always_comb begin
    overflow_d = overflow_q;
    if (p1_valid_q) begin
      // The index-0 output restarts the per-frame sticky flag.
      if (p1_first_q) begin
        overflow_d = sat & ~p1_warm_q;
      end else if (!p1_warm_q) begin
        overflow_d = overflow_q | sat;
      end
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      valid_q       <= 1'b0;
      warm_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      residual_q    <= '0;
      warm_sample_q <= '0;
      m_q           <= '0;
    end else if (iEnable) begin
      valid_q      <= p1_valid_q & ~p1_warm_q;
      warm_valid_q <= p1_valid_q & p1_warm_q;
      frame_done_q <= p1_valid_q & p1_last_q;
      overflow_q   <= overflow_d;
      if (p1_valid_q) begin
        if (p1_warm_q) begin
          warm_sample_q <= p1_x_q;
        end else begin
          residual_q <= res;
        end
        if (p1_first_q) begin
          m_q <= {1'b0, p1_order_q};
        end
      end
    end
  end

  // Strobes read low whenever the pipeline is frozen.
  assign oValid      = valid_q & iEnable;
  assign oWarmValid  = warm_valid_q & iEnable;
  assign oFrameDone  = frame_done_q & iEnable;
  assign oResidual   = residual_q;
  assign oWarmSample = warm_sample_q;
  assign oM          = m_q;
  assign oOverflow   = overflow_q;

endmodule

// File: tb/tb_stage3_fixed_residual.sv
// Directed bench for stage3_fixed_residual; outputs trail the pushed sample by one push.
module tb_stage3_fixed_residual;

  logic        iClock;
  logic        iReset_n;
  logic        iEnable;
  logic        iValid;
  logic [15:0] iSample;
  logic [2:0]  iOrder;
  logic        oValid;
  logic [15:0] oResidual;
  logic        oWarmValid;
  logic [15:0] oWarmSample;
  logic [3:0]  oM;
  logic        oFrameDone;
  logic        oOverflow;

  int checks = 0;
  int errors = 0;

  stage3_fixed_residual #(.FRAME_SIZE(4096)) dut (
    .iClock      (iClock),
    .iReset_n    (iReset_n),
    .iEnable     (iEnable),
    .iValid      (iValid),
    .iSample     (iSample),
    .iOrder      (iOrder),
    .oValid      (oValid),
    .oResidual   (oResidual),
    .oWarmValid  (oWarmValid),
    .oWarmSample (oWarmSample),
    .oM          (oM),
    .oFrameDone  (oFrameDone),
    .oOverflow   (oOverflow)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 = no strobe, 1 = warm-up sample, 2 = residual
  task automatic chk_out(input string tag, input int kind, input logic [15:0] val);
    logic [31:0] ev;
    logic [31:0] ew;
    ev = (kind == 2) ? 32'd1 : 32'd0;
    ew = (kind == 1) ? 32'd1 : 32'd0;
    chk({tag, "_oValid"}, {31'd0, oValid}, ev);
    chk({tag, "_oWarmValid"}, {31'd0, oWarmValid}, ew);
    if (kind == 1) chk({tag, "_oWarmSample"}, {16'd0, oWarmSample}, {16'd0, val});
    if (kind == 2) chk({tag, "_oResidual"}, {16'd0, oResidual}, {16'd0, val});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_oValid"}, {31'd0, oValid}, 32'd0);
    chk({tag, "_oWarmValid"}, {31'd0, oWarmValid}, 32'd0);
    chk({tag, "_oFrameDone"}, {31'd0, oFrameDone}, 32'd0);
    chk({tag, "_oOverflow"}, {31'd0, oOverflow}, 32'd0);
    chk({tag, "_oResidual"}, {16'd0, oResidual}, 32'd0);
    chk({tag, "_oWarmSample"}, {16'd0, oWarmSample}, 32'd0);
    chk({tag, "_oM"}, {28'd0, oM}, 32'd0);
  endtask

  task automatic push(input logic v, input logic [15:0] s);
    iValid  = v;
    iSample = s;
    @(posedge iClock);
    #1;
  endtask

  task automatic do_reset(input string tag);
    iValid   = 1'b0;
    iReset_n = 1'b0;
    #2;
    chk_zero(tag);
    iReset_n = 1'b1;
    @(posedge iClock);
    #1;
  endtask

  initial begin
    iReset_n = 1'b0;
    iEnable  = 1'b0;
    iValid   = 1'b0;
    iSample  = '0;
    iOrder   = '0;
    #2;
    chk_zero("por");
    #1 iReset_n = 1'b1;
    @(posedge iClock);
    #1;
    iEnable = 1'b1;

    // Order 2 ramp: two warm samples then zero residuals
    iOrder = 3'd2;
    push(1'b1, 16'd10); chk_out("o2_s0", 0, 16'd0);
    push(1'b1, 16'd20); chk_out("o2_w10", 1, 16'd10);
    chk("o2_oM", {28'd0, oM}, 32'd2);
    push(1'b1, 16'd30); chk_out("o2_w20", 1, 16'd20);
    push(1'b1, 16'd40); chk_out("o2_r30", 2, 16'd0);
    push(1'b1, 16'd50); chk_out("o2_r40", 2, 16'd0);
    push(1'b0, 16'd0);  chk_out("o2_r50", 2, 16'd0);
    push(1'b0, 16'd0);  chk_out("o2_gap", 0, 16'd0);

    // Order request 7 clamps to 4: impulse response 1, -4
    do_reset("rst_o4");
    iOrder = 3'd7;
    push(1'b1, 16'd0); chk_out("o4_s0", 0, 16'd0);
    push(1'b1, 16'd0); chk_out("o4_w0", 1, 16'd0);
    chk("o4_oM", {28'd0, oM}, 32'd4);
    push(1'b1, 16'd0); chk_out("o4_w1", 1, 16'd0);
    push(1'b1, 16'd0); chk_out("o4_w2", 1, 16'd0);
    push(1'b1, 16'd1); chk_out("o4_w3", 1, 16'd0);
    push(1'b1, 16'd0); chk_out("o4_r1", 2, 16'd1);
    push(1'b0, 16'd0); chk_out("o4_rm4", 2, 16'hFFFC);

    // Order 1 full-scale step: -65535 saturates or wraps
    do_reset("rst_sat");
    iOrder = 3'd1;
    push(1'b1, 16'h7FFF); chk_out("sat_s0", 0, 16'd0);
    push(1'b1, 16'h8000); chk_out("sat_w", 1, 16'h7FFF);
    push(1'b0, 16'd0);
`ifdef STAGE3_SATURATE_EN
    chk_out("sat_r", 2, 16'h8000);
    chk("sat_ovf", {31'd0, oOverflow}, 32'd1);
`else
    chk_out("sat_r", 2, 16'h0001);
    chk("sat_ovf", {31'd0, oOverflow}, 32'd0);
`endif

    // Order 2 with a 5-cycle stall: residuals 11, -22, 1 as without the stall
    do_reset("rst_stall");
    iOrder = 3'd2;
    push(1'b1, 16'd5);  chk_out("st_s0", 0, 16'd0);
    push(1'b1, 16'd7);  chk_out("st_w5", 1, 16'd5);
    push(1'b1, 16'd20); chk_out("st_w7", 1, 16'd7);
    iEnable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(1'b1, 16'd999);
      chk_out("st_hold", 0, 16'd0);
      chk("st_hold_oFrameDone", {31'd0, oFrameDone}, 32'd0);
    end
    iEnable = 1'b1;
    push(1'b1, 16'd11); chk_out("st_r20", 2, 16'd11);
    push(1'b1, 16'd3);  chk_out("st_r11", 2, 16'hFFEA);
    push(1'b0, 16'd0);  chk_out("st_r3", 2, 16'd1);
    push(1'b0, 16'd0);  chk_out("st_gap", 0, 16'd0);

    // Order 0 passthrough up to index 999, then reset mid-frame and restart at order 3
    do_reset("rst_o0");
    iOrder = 3'd0;
    for (int i = 0; i < 1000; i++) begin
      push(1'b1, 16'(i));
      if (i == 1) chk("o0_oM", {28'd0, oM}, 32'd0);
      if (i > 0) chk_out("o0_r", 2, 16'(i - 1));
    end
    do_reset("rst_mid");
    iOrder = 3'd3;
    push(1'b1, 16'd7);  chk_out("o3_s0", 0, 16'd0);
    push(1'b1, 16'd8);  chk_out("o3_w7", 1, 16'd7);
    chk("o3_oM", {28'd0, oM}, 32'd3);
    push(1'b1, 16'd9);  chk_out("o3_w8", 1, 16'd8);
    push(1'b1, 16'd10); chk_out("o3_w9", 1, 16'd9);
    push(1'b0, 16'd0);  chk_out("o3_r10", 2, 16'd0);

    // Full order-1 frame of constant 100, then wrap into the next frame
    do_reset("rst_frame");
    iOrder = 3'd1;
    for (int i = 0; i < 4096; i++) begin
      push(1'b1, 16'd100);
      if (i > 0) begin
        chk_out("fr_out", (i == 1) ? 1 : 2, (i == 1) ? 16'd100 : 16'd0);
        chk("fr_done", {31'd0, oFrameDone}, 32'd0);
      end
    end
    push(1'b1, 16'd100);
    chk_out("fr_last", 2, 16'd0);
    chk("fr_last_done", {31'd0, oFrameDone}, 32'd1);
    chk("fr_oM", {28'd0, oM}, 32'd1);
    push(1'b0, 16'd0);
    chk_out("fr_next_w", 1, 16'd100);
    chk("fr_next_done", {31'd0, oFrameDone}, 32'd0);
    push(1'b0, 16'd0);
    chk_out("fr_tail", 0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage3_fixed_residual.md
STAGE3_FIXED_RESIDUAL -- requirements
Module: stage3_fixed_residual

Interface
REQ-001 SHALL have parameter FRAME_SIZE, default 4096: samples per frame, range 8..4096.
REQ-002 SHALL have port iClock  input  1  rising-edge clock.
REQ-003 SHALL have port iReset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port iEnable  input  1  global advance; low freezes all state.
REQ-005 SHALL have port iValid  input  1  iSample is valid this cycle.
REQ-006 SHALL have port iSample  input  16  signed PCM sample.
REQ-007 SHALL have port iOrder  input  3  fixed-predictor order request, 0..4.
REQ-008 SHALL have port oValid  output  1  oResidual valid; feeds Stage4 iValid.
REQ-009 SHALL have port oResidual  output  16  signed residual.
REQ-010 SHALL have port oWarmValid  output  1  oWarmSample valid.
REQ-011 SHALL have port oWarmSample  output  16  verbatim warm-up sample for the header writer.
REQ-012 SHALL have port oM  output  4  order of the frame currently being output; feeds Stage4 iM.
REQ-013 SHALL have port oFrameDone  output  1  one-cycle pulse on the frame's last output; feeds Stage4 iFrameDone.
REQ-014 SHALL have port oOverflow  output  1  sticky flag: a residual was saturated in this frame.

Function
REQ-015 SHALL count accepted samples (iEnable & iValid) with a 12-bit index 0..FRAME_SIZE-1; the index wraps to 0 after FRAME_SIZE-1.
REQ-016 SHALL latch iOrder when the index-0 sample is accepted; values 5..7 clamp to 4; the latched order is held for the whole frame.
REQ-017 SHALL hold a 4-deep history x1..x4 of accepted samples; history shifts only on accepted samples.
REQ-018 SHALL compute the residual e with 20-bit signed arithmetic. Order 0: x. Order 1: x-x1. Order 2: x-2x1+x2. Order 3: x-3x1+3x2-x3. Order 4: x-4x1+6x2-4x3+x4.
REQ-019 SHALL route samples with index < order to oWarmSample/oWarmValid, with oValid=0.
REQ-020 SHALL route all other samples to oResidual/oValid, with oWarmValid=0.
REQ-021 SHALL have a fixed latency of 2 enabled cycles from sample acceptance to the corresponding oValid/oWarmValid.
REQ-022 SHALL ignore history from the previous frame: warm-up handling guarantees history is fully refilled before the first residual.
REQ-023 SHALL update oM 2 enabled cycles after the index-0 sample, aligned with that sample's output, and hold it until the next frame's index-0 output.
REQ-024 SHALL pulse oFrameDone in the same cycle as the output of index FRAME_SIZE-1.
REQ-025 SHALL gate oValid, oWarmValid and oFrameDone with iEnable; when iEnable is low, all registers hold and these strobes read 0.
REQ-026 SHALL accept gaps in iValid: the counter and history do not advance, and no output strobe is generated for the gap.
REQ-027 SHALL clear oOverflow with the index-0 output of each frame and set it on any saturated residual.
REQ-028 SHALL, with order 0, emit no warm-up samples and emit FRAME_SIZE residuals equal to the input.

Reset
REQ-029 SHALL, on iReset_n low, asynchronously clear: index, history, latched order, pipeline registers, oValid, oWarmValid, oFrameDone, oOverflow, oResidual, oWarmSample and oM (all to 0).
REQ-030 SHALL, on reset asserted mid-frame, discard the partial frame; the first sample accepted after release is index 0 of a new frame.
REQ-031 SHALL release reset synchronously internally; the first enabled edge after deassertion may accept a sample.

Configuration
REQ-032 SHALL, with STAGE3_SATURATE_EN defined, clamp the 20-bit residual to [-32768, 32767] and set oOverflow on clamping.
REQ-033 SHALL, without STAGE3_SATURATE_EN, truncate the residual to its low 16 bits and tie oOverflow to 0.

Verification
REQ-034 SHALL cover order 2 with samples 10,20,30,40,50 -> oWarmSample 10,20, then oResidual 0,0,0, oM=2.
REQ-035 SHALL cover order 1 with constant 100 for a full frame -> one warm 100, then 4095 residuals of 0, and oFrameDone on the 4096th output.
REQ-036 SHALL cover order 4 with samples 0,0,0,0,1 -> four warm 0s, then residual 1; next sample 0 -> residual -4.
REQ-037 SHALL cover, with STAGE3_SATURATE_EN and order 1, samples 32767 then -32768 -> residual -32768 and oOverflow=1; without the macro -> residual 1 and oOverflow=0.
REQ-038 SHALL cover iReset_n pulsed at index 1000, then order 3 requested -> oWarmValid for the next 3 samples and oM=3.
REQ-039 SHALL cover iEnable low for 5 cycles mid-frame -> no strobes during the stall and residual values unchanged versus an unstalled run.
